// File: rtl/vel_sched_pkg.sv
// Shared types and defaults for the velocity sample scheduler.
package vel_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSelect,
    StCapture,
    StPresent
  } state_e;

  localparam int unsigned DefPosW = 16;
  localparam int unsigned DefVelW = 12;

  function automatic int unsigned ch_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vel_delta.sv
// Combinational position-delta to velocity reduction.
// VEL_SAMPLE_SCHED_SAT_EN selects saturation (with sat flag) instead of two's-complement truncation.
module vel_delta
  import vel_sched_pkg::*;
#(
  parameter int unsigned PosW = DefPosW,
  parameter int unsigned VelW = DefVelW
) (
  input  logic [PosW-1:0] cur,
  input  logic [PosW-1:0] prev,
  output logic [VelW-1:0] vel
`ifdef VEL_SAMPLE_SCHED_SAT_EN
  ,
  output logic            sat
`endif
);

`ifdef VEL_SAMPLE_SCHED_SAT_EN
  logic [PosW-1:0] diff;
  logic [PosW:0]   delta;
  logic            hi_ones;
  logic            hi_zeros;

  // Subtraction wraps in PosW bits first, so a counter rollover reads as a small step.
  always_comb begin
    diff     = cur - prev;
    delta    = {diff[PosW-1], diff};
    hi_ones  = &delta[PosW:VelW-1];
    hi_zeros = ~|delta[PosW:VelW-1];
    sat      = !(hi_ones || hi_zeros);
    if (!sat) begin
      vel = delta[VelW-1:0];
    end else if (delta[PosW]) begin
      vel = {1'b1, {(VelW-1){1'b0}}};
    end else begin
      vel = {1'b0, {(VelW-1){1'b1}}};
    end
  end
`else
  assign vel = VelW'(cur - prev);
`endif

endmodule

// File: rtl/vel_sample_sched.sv
// Per-tick scan of NUM_CH position counters producing velocity records over valid/ready.
// VEL_SAMPLE_SCHED_SAT_EN adds saturation and the vel_sat output.
module vel_sample_sched
  import vel_sched_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned POS_W  = DefPosW,
  parameter int unsigned VEL_W  = DefVelW,
  localparam int unsigned CH_W  = ch_w(NUM_CH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             enable,
  output logic [CH_W-1:0]  ch_sel,
  input  logic [POS_W-1:0] pos_in,
  output logic [VEL_W-1:0] vel_data,
  output logic [CH_W-1:0]  vel_ch,
  output logic             vel_valid,
  input  logic             vel_ready,
  output logic             busy,
  output logic             overrun
`ifdef VEL_SAMPLE_SCHED_SAT_EN
  ,
  output logic             vel_sat
`endif
);

  localparam logic [CH_W-1:0] LastCh = CH_W'(NUM_CH - 1);

  state_e           state_q;
  logic [CH_W-1:0]  ch_q;
  logic [CH_W-1:0]  ch_sel_q;
  logic [CH_W-1:0]  vel_ch_q;
  logic [VEL_W-1:0] vel_data_q;
  logic             vel_valid_q;
  logic             busy_q;
  logic             overrun_q;
  logic [POS_W-1:0] prev_q [NUM_CH];
  logic [NUM_CH-1:0] primed_q;
  logic [POS_W-1:0] prev_sel;
  logic [VEL_W-1:0] delta_vel;

`ifdef VEL_SAMPLE_SCHED_SAT_EN
  logic delta_sat;
  logic vel_sat_q;
`endif

  assign prev_sel = prev_q[ch_q];

  vel_delta #(
    .PosW(POS_W),
    .VelW(VEL_W)
  ) u_delta (
    .cur (pos_in),
    .prev(prev_sel),
    .vel (delta_vel)
`ifdef VEL_SAMPLE_SCHED_SAT_EN
    ,
    .sat (delta_sat)
`endif
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      ch_q        <= '0;
      ch_sel_q    <= '0;
      vel_ch_q    <= '0;
      vel_data_q  <= '0;
      vel_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      primed_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        prev_q[i] <= '0;
      end
`ifdef VEL_SAMPLE_SCHED_SAT_EN
      vel_sat_q   <= 1'b0;
`endif
    end else begin
      // busy is still high on the final-accept cycle, so a tick there is an overrun.
      if (tick && busy_q) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (tick && enable) begin
            state_q  <= StSelect;
            ch_q     <= '0;
            ch_sel_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        StSelect: begin
          state_q <= StCapture;
        end
        StCapture: begin
          prev_q[ch_q] <= pos_in;
          vel_ch_q     <= ch_q;
          vel_valid_q  <= 1'b1;
          state_q      <= StPresent;
          if (!primed_q[ch_q]) begin
            primed_q[ch_q] <= 1'b1;
            vel_data_q     <= '0;
`ifdef VEL_SAMPLE_SCHED_SAT_EN
            vel_sat_q      <= 1'b0;
`endif
          end else begin
            vel_data_q <= delta_vel;
`ifdef VEL_SAMPLE_SCHED_SAT_EN
            vel_sat_q  <= delta_sat;
`endif
          end
        end
        StPresent: begin
          if (vel_ready) begin
            vel_valid_q <= 1'b0;
            if (ch_q == LastCh) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end else begin
              ch_q     <= ch_q + 1'b1;
              ch_sel_q <= ch_q + 1'b1;
              state_q  <= StSelect;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ch_sel    = ch_sel_q;
  assign vel_data  = vel_data_q;
  assign vel_ch    = vel_ch_q;
  assign vel_valid = vel_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
`ifdef VEL_SAMPLE_SCHED_SAT_EN
  assign vel_sat   = vel_sat_q;
`endif

endmodule

// File: tb/tb_vel_sample_sched.sv
// Self-checking bench for vel_sample_sched against a behavioural velocity model.
module tb_vel_sample_sched;

  localparam int unsigned NumCh = 4;
  localparam int unsigned PosW  = 16;
  localparam int unsigned VelW  = 12;
  localparam int unsigned ChW   = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            tick = 1'b0;
  logic            enable = 1'b1;
  logic [ChW-1:0]  ch_sel;
  logic [PosW-1:0] pos_in = '0;
  logic [VelW-1:0] vel_data;
  logic [ChW-1:0]  vel_ch;
  logic            vel_valid;
  logic            vel_ready;
  logic            busy;
  logic            overrun;
  logic            dut_sat;
  logic            ready_rand = 1'b0;
  logic            ready_force = 1'b1;
  logic            rand_bit = 1'b1;

  logic [PosW-1:0] pos_tb [NumCh];
  int vectors = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int              ch;
    logic [VelW-1:0] data;
    bit              sat;
    int              cyc;
  } rec_t;

  rec_t got_q[$];
  rec_t exp_q[$];
  int   m_prev[NumCh];
  bit   m_primed[NumCh];

`ifdef VEL_SAMPLE_SCHED_SAT_EN
  logic vel_sat;
  assign dut_sat = vel_sat;
`else
  assign dut_sat = 1'b0;
`endif

  vel_sample_sched #(
    .NUM_CH(NumCh),
    .POS_W (PosW),
    .VEL_W (VelW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .tick     (tick),
    .enable   (enable),
    .ch_sel   (ch_sel),
    .pos_in   (pos_in),
    .vel_data (vel_data),
    .vel_ch   (vel_ch),
    .vel_valid(vel_valid),
    .vel_ready(vel_ready),
    .busy     (busy),
    .overrun  (overrun)
`ifdef VEL_SAMPLE_SCHED_SAT_EN
    ,
    .vel_sat  (vel_sat)
`endif
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rand_bit <= 1'($urandom);
  always @(posedge clk) pos_in <= pos_tb[ch_sel];

  assign vel_ready = ready_rand ? rand_bit : ready_force;

  // Records are taken mid-cycle; valid && ready here means the next edge accepts.
  always @(negedge clk) begin
    rec_t r;
    if (reset_n && vel_valid && vel_ready) begin
      r.ch   = int'(vel_ch);
      r.data = vel_data;
      r.sat  = dut_sat;
      r.cyc  = cyc;
      got_q.push_back(r);
    end
  end

  function automatic void model_reset();
    for (int i = 0; i < NumCh; i++) begin
      m_prev[i]   = 0;
      m_primed[i] = 1'b0;
    end
  endfunction

  // Expected records for one scan of the current pos_tb values.
  function automatic void model_scan();
    for (int i = 0; i < NumCh; i++) begin
      rec_t r;
      int cur, d, t;
      cur   = int'(pos_tb[i]);
      r.ch  = i;
      r.sat = 1'b0;
      r.cyc = 0;
      if (!m_primed[i]) begin
        r.data      = '0;
        m_primed[i] = 1'b1;
      end else begin
        d = (cur - m_prev[i] + 65536) % 65536;
        if (d >= 32768) d = d - 65536;
`ifdef VEL_SAMPLE_SCHED_SAT_EN
        if (d > 2047) begin
          d = 2047;
          r.sat = 1'b1;
        end else if (d < -2048) begin
          d = -2048;
          r.sat = 1'b1;
        end
`endif
        t = ((d % 4096) + 4096) % 4096;
        r.data = t[VelW-1:0];
      end
      m_prev[i] = cur;
      exp_q.push_back(r);
    end
  endfunction

  task automatic set_pos(input int p0, input int p1, input int p2, input int p3);
    pos_tb[0] = 16'(p0);
    pos_tb[1] = 16'(p1);
    pos_tb[2] = 16'(p2);
    pos_tb[3] = 16'(p3);
  endtask

  task automatic launch_tick();
    @(posedge clk); #2;
    tick = 1'b1;
    @(posedge clk); #2;
    tick = 1'b0;
  endtask

  task automatic wait_idle(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic wait_valid(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (vel_valid) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic run_scan(output bit timed_out);
    launch_tick();
    wait_idle(timed_out);
  endtask

  task automatic test_reset();
    #15;
    vectors++;
    if (ch_sel !== '0 || vel_data !== '0 || vel_ch !== '0 || vel_valid !== 1'b0 ||
        busy !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got sel=%h data=%h ch=%h v=%b busy=%b ovr=%b, want all 0",
               ch_sel, vel_data, vel_ch, vel_valid, busy, overrun);
    end
    @(posedge clk); #2;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_priming();
    bit to;
    set_pos(100, 100, 100, 100);
    model_scan();
    run_scan(to);
    vectors++;
    if (to || got_q.size() != NumCh) begin
      errors++;
      $display("FAIL prime_count got %0d records timeout=%0d, want 4", got_q.size(), to);
    end else begin
      for (int i = 0; i < NumCh; i++) begin
        vectors++;
        if (got_q[i].ch != i || got_q[i].data !== 12'd0) begin
          errors++;
          $display("FAIL prime_first got ch%0d %h, want ch%0d 000", got_q[i].ch, got_q[i].data, i);
        end
      end
    end
    got_q.delete();
    set_pos(130, 130, 130, 130);
    model_scan();
    run_scan(to);
    vectors++;
    if (to || got_q.size() != NumCh) begin
      errors++;
      $display("FAIL prime2_count got %0d records timeout=%0d, want 4", got_q.size(), to);
    end else begin
      for (int i = 0; i < NumCh; i++) begin
        vectors++;
        if (got_q[i].ch != i || got_q[i].data !== 12'd30) begin
          errors++;
          $display("FAIL prime_second got ch%0d %h, want ch%0d 01e", got_q[i].ch, got_q[i].data, i);
        end
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    bit to;
    int n;
    rec_t g, e;
    ready_force = 1'b1;
    for (int i = 0; i < NumCh; i++) pos_tb[i] = 16'($urandom);
    model_scan();
    @(posedge clk); #2;
    tick = 1'b1;
    @(posedge clk); #2;
    tick = 1'b0;
    n = 1;
    while (!vel_valid && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    vectors++;
    if (n != 3) begin
      errors++;
      $display("FAIL latency got %0d cycles, want 3", n);
    end
    wait_idle(to);
    vectors++;
    if (to || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count got %0d timeout=%0d, want %0d", got_q.size(), to, exp_q.size());
    end
    for (int i = 1; i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i].cyc - got_q[i-1].cyc != 3) begin
        errors++;
        $display("FAIL b2b_period got %0d cycles, want 3", got_q[i].cyc - got_q[i-1].cyc);
      end
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      if (g.ch != e.ch || g.data !== e.data || g.sat != e.sat) begin
        errors++;
        $display("FAIL b2b_rec got ch%0d %h sat%0d, want ch%0d %h sat%0d",
                 g.ch, g.data, g.sat, e.ch, e.data, e.sat);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    bit to;
    logic [VelW-1:0] d0;
    logic [ChW-1:0]  c0, s0;
    rec_t g, e;
    ready_force = 1'b0;
    for (int i = 0; i < NumCh; i++) pos_tb[i] = 16'($urandom);
    model_scan();
    launch_tick();
    wait_valid(to);
    ready_force = 1'b1;
    @(posedge clk); #2;
    ready_force = 1'b0;
    wait_valid(to);
    d0 = vel_data;
    c0 = vel_ch;
    s0 = ch_sel;
    vectors++;
    if (to || c0 !== 2'd1) begin
      errors++;
      $display("FAIL bp_channel got ch%0d timeout=%0d, want ch1", c0, to);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      vectors++;
      if (vel_valid !== 1'b1 || vel_data !== d0 || vel_ch !== c0 || ch_sel !== s0) begin
        errors++;
        $display("FAIL bp_hold got v=%b %h ch%0d sel%0d, want v=1 %h ch%0d sel%0d",
                 vel_valid, vel_data, vel_ch, ch_sel, d0, c0, s0);
      end
    end
    ready_force = 1'b1;
    @(posedge clk); #2;
    vectors++;
    if (vel_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_gap1 got valid=%b, want 0", vel_valid);
    end
    @(posedge clk); #2;
    vectors++;
    if (vel_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_gap2 got valid=%b, want 0", vel_valid);
    end
    @(posedge clk); #2;
    vectors++;
    if (vel_valid !== 1'b1 || vel_ch !== 2'd2) begin
      errors++;
      $display("FAIL bp_next got valid=%b ch%0d, want valid=1 ch2", vel_valid, vel_ch);
    end
    wait_idle(to);
    vectors++;
    if (to || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL bp_count got %0d timeout=%0d, want %0d", got_q.size(), to, exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      if (g.ch != e.ch || g.data !== e.data || g.sat != e.sat) begin
        errors++;
        $display("FAIL bp_rec got ch%0d %h sat%0d, want ch%0d %h sat%0d",
                 g.ch, g.data, g.sat, e.ch, e.data, e.sat);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_wrap();
    bit to;
    set_pos(16'h7FFE, 16'h0002, 0, 0);
    model_scan();
    run_scan(to);
    got_q.delete();
    set_pos(16'h8003, 16'hFFFD, 0, 0);
    model_scan();
    run_scan(to);
    vectors++;
    if (to || got_q.size() != NumCh) begin
      errors++;
      $display("FAIL wrap_count got %0d timeout=%0d, want 4", got_q.size(), to);
    end else begin
      vectors++;
      if (got_q[0].data !== 12'h005) begin
        errors++;
        $display("FAIL wrap_pos got %h, want 005", got_q[0].data);
      end
      vectors++;
      if (got_q[1].data !== 12'hFFB) begin
        errors++;
        $display("FAIL wrap_neg got %h, want ffb", got_q[1].data);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_saturation();
    bit to;
    logic [VelW-1:0] want [NumCh];
    bit want_sat [NumCh];
`ifdef VEL_SAMPLE_SCHED_SAT_EN
    want[0] = 12'h7FF; want_sat[0] = 1'b1;
    want[1] = 12'h800; want_sat[1] = 1'b1;
`else
    want[0] = 12'hBB8; want_sat[0] = 1'b0;
    want[1] = 12'h448; want_sat[1] = 1'b0;
`endif
    want[2] = 12'h7FF; want_sat[2] = 1'b0;
    want[3] = 12'h800; want_sat[3] = 1'b0;
    set_pos(1000, 1000, 1000, 1000);
    model_scan();
    run_scan(to);
    got_q.delete();
    set_pos(1000 + 3000, 1000 - 3000, 1000 + 2047, 1000 - 2048);
    model_scan();
    run_scan(to);
    vectors++;
    if (to || got_q.size() != NumCh) begin
      errors++;
      $display("FAIL sat_count got %0d timeout=%0d, want 4", got_q.size(), to);
    end else begin
      for (int i = 0; i < NumCh; i++) begin
        vectors++;
        if (got_q[i].data !== want[i] || got_q[i].sat != want_sat[i]) begin
          errors++;
          $display("FAIL sat_ch%0d got %h sat%0d, want %h sat%0d",
                   i, got_q[i].data, got_q[i].sat, want[i], want_sat[i]);
        end
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_enable();
    bit to;
    rec_t g, e;
    enable = 1'b0;
    launch_tick();
    repeat (5) @(posedge clk);
    #2;
    vectors++;
    if (busy !== 1'b0 || got_q.size() != 0) begin
      errors++;
      $display("FAIL enable_block got busy=%b records=%0d, want 0 0", busy, got_q.size());
    end
    enable = 1'b1;
    for (int i = 0; i < NumCh; i++) pos_tb[i] = 16'($urandom);
    model_scan();
    launch_tick();
    enable = 1'b0;
    wait_idle(to);
    enable = 1'b1;
    vectors++;
    if (to || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL enable_mid got %0d timeout=%0d, want %0d", got_q.size(), to, exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      if (g.ch != e.ch || g.data !== e.data || g.sat != e.sat) begin
        errors++;
        $display("FAIL enable_rec got ch%0d %h, want ch%0d %h", g.ch, g.data, e.ch, e.data);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_overrun();
    bit to;
    ready_force = 1'b0;
    for (int i = 0; i < NumCh; i++) pos_tb[i] = 16'($urandom);
    model_scan();
    launch_tick();
    wait_valid(to);
    vectors++;
    if (to || overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_pre got overrun=%b timeout=%0d, want 0", overrun, to);
    end
    launch_tick();
    vectors++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set got %b, want 1", overrun);
    end
    ready_force = 1'b1;
    wait_idle(to);
    repeat (20) @(posedge clk);
    #2;
    vectors++;
    if (to || got_q.size() != NumCh || busy !== 1'b0) begin
      errors++;
      $display("FAIL ovr_records got %0d busy=%b, want 4 busy=0", got_q.size(), busy);
    end
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < NumCh; i++) pos_tb[i] = 16'($urandom);
    model_scan();
    launch_tick();
    vectors++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL ovr_restart got busy=%b, want 1", busy);
    end
    wait_idle(to);
    vectors++;
    if (to || got_q.size() != NumCh || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_after got %0d records overrun=%b, want 4 1", got_q.size(), overrun);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    bit to;
    ready_force = 1'b0;
    for (int i = 0; i < NumCh; i++) pos_tb[i] = 16'($urandom);
    launch_tick();
    wait_valid(to);
    #3;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (to || vel_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got valid=%b busy=%b ovr=%b timeout=%0d, want 0 0 0",
               vel_valid, busy, overrun, to);
    end
    @(posedge clk); #2;
    reset_n = 1'b1;
    model_reset();
    got_q.delete();
    exp_q.delete();
    ready_force = 1'b1;
    model_scan();
    run_scan(to);
    vectors++;
    if (to || got_q.size() != NumCh) begin
      errors++;
      $display("FAIL rst_count got %0d timeout=%0d, want 4", got_q.size(), to);
    end else begin
      for (int i = 0; i < NumCh; i++) begin
        vectors++;
        if (got_q[i].ch != i || got_q[i].data !== 12'd0) begin
          errors++;
          $display("FAIL rst_unprimed got ch%0d %h, want ch%0d 000", got_q[i].ch, got_q[i].data, i);
        end
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    bit to;
    rec_t g, e;
    int step;
    ready_rand = 1'b1;
    for (int s = 0; s < 20; s++) begin
      for (int i = 0; i < NumCh; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          step = int'($urandom_range(0, 6000)) - 3000;
          pos_tb[i] = 16'(int'(pos_tb[i]) + step);
        end else begin
          pos_tb[i] = 16'($urandom);
        end
      end
      model_scan();
      run_scan(to);
      vectors++;
      if (to || got_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand_count scan %0d got %0d timeout=%0d, want %0d",
                 s, got_q.size(), to, exp_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
        g = got_q.pop_front();
        e = exp_q.pop_front();
        vectors++;
        if (g.ch != e.ch || g.data !== e.data || g.sat != e.sat) begin
          errors++;
          $display("FAIL rand_rec scan %0d got ch%0d %h sat%0d, want ch%0d %h sat%0d",
                   s, g.ch, g.data, g.sat, e.ch, e.data, e.sat);
        end
      end
      got_q.delete();
      exp_q.delete();
    end
    ready_rand = 1'b0;
    ready_force = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NumCh; i++) pos_tb[i] = '0;
    test_reset();
    test_priming();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_saturation();
    test_enable();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vel_sample_sched.md
Name: vel_sample_sched

Overview:
- Sample scheduler for the motor-position lab datapath.
- On each periodic tick pulse (~30 Hz from the free-running tick timer), it sequences a scan over NUM_CH quadrature position counters through a shared registered mux.
- For each channel it computes velocity as the position delta since the previous tick and delivers one velocity record per channel over a valid/ready handshake to the display/logging consumer.
- It also flags ticks that arrive while a scan is still in progress (overrun).

Parameters:
- NUM_CH, 4, number of position-counter channels scanned per tick (2..8).
- POS_W, 16, width of the signed position counter value.
- VEL_W, 12, width of the signed velocity output.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous active-low reset.
- tick  in  1  one-cycle pulse from the tick timer; starts a scan.
- enable  in  1  when low, ticks are ignored; an in-progress scan completes.
- ch_sel  out  $clog2(NUM_CH)  select for the shared position mux.
- pos_in  in  POS_W  signed position of the selected channel; valid exactly 1 cycle after ch_sel changes (registered mux).
- vel_data  out  VEL_W  signed velocity record.
- vel_ch  out  $clog2(NUM_CH)  channel index of vel_data.
- vel_valid  out  1  record valid.
- vel_ready  in  1  consumer accepts the record when vel_valid && vel_ready.
- busy  out  1  high from the scan start until the last record is accepted.
- overrun  out  1  sticky; set when tick arrives while busy; cleared only by reset.

Behaviour:
- Reset values: ch_sel=0, vel_data=0, vel_ch=0, vel_valid=0, busy=0, overrun=0, state=IDLE. All prev_pos[]=0, all primed[]=0.
- FSM states: IDLE, SELECT, CAPTURE, PRESENT.
  - IDLE: on tick && enable, go to SELECT with ch=0 and set busy=1.
  - SELECT: drive ch_sel=ch for one cycle (mux settle), then go to CAPTURE.
  - CAPTURE: sample pos_in and compute delta = pos_in - prev_pos[ch] in POS_W+1 bits. Then:
    - if primed[ch]=0: vel_data=0 and set primed[ch]=1;
    - otherwise vel_data = delta reduced to VEL_W (see Optional Feature).
    - In all cases: prev_pos[ch]=pos_in, vel_ch=ch, vel_valid=1, go to PRESENT.
  - PRESENT: hold vel_data, vel_ch and vel_valid stable until vel_ready. On accept, drop vel_valid. If ch==NUM_CH-1, go to IDLE and set busy=0; otherwise increment ch and go to SELECT.
- Latency: tick to first vel_valid is 3 cycles. Minimum per-channel period with vel_ready held high is 3 cycles.
- Tick while busy: the tick is ignored for scheduling and overrun is set. The current scan is not restarted.
- Tick in the same cycle as the final accept: busy is still 1, so the tick counts as an overrun.
- Position wrap: the subtraction is modular in POS_W bits before sign extension. A counter wrap from 0x7FFF to 0x8000 yields delta=+1, not a large negative value.
- enable deasserted mid-scan: the scan runs to completion; only new ticks are blocked.
- Async reset mid-scan: all state clears immediately. The next scan starts unprimed, with velocity 0 for every channel.
- vel_valid must never drop without a handshake. vel_data must not change while vel_valid=1 && !vel_ready.

Optional Feature:
- Macro: VEL_SAMPLE_SCHED_SAT_EN.
- Defined: delta is saturated to the signed VEL_W range, i.e. [-2^(VEL_W-1), 2^(VEL_W-1)-1]. Saturation sets an extra output port vel_sat (1 bit) for that record.
- Undefined: delta is truncated to its low VEL_W bits (two's-complement wrap) and the vel_sat port is absent.

Decomposition:
- Shared package vel_sched_pkg contains:
  - the state enum (IDLE, SELECT, CAPTURE, PRESENT);
  - the CH_W localparam function based on $clog2;
  - default widths for POS_W and VEL_W.
- Sub-module vel_delta: purely combinational.
  - Inputs: cur, prev.
  - Outputs: vel, sat.
  - Handles modular subtraction and the saturate/truncate option, so the FSM stays free of arithmetic.

Test Plan:
- Priming: reset, apply pos_in=100 on all channels, tick -> four records, ch 0..3, vel_data=0 each. Second tick with pos_in=130 -> vel_data=30 each.
- Backpressure: hold vel_ready=0 for 10 cycles during the ch1 record -> vel_valid, vel_data and vel_ch are stable throughout; ch_sel does not advance; then ch2 follows 2 cycles after accept.
- Wrap: prev=0x7FFE, cur=0x8003 -> vel_data=+5. prev=0x0002, cur=0xFFFD -> vel_data=-5.
- Saturation: with SAT_EN, VEL_W=12, delta=+3000 -> vel_data=2047, vel_sat=1. Without the macro -> vel_data = 3000 mod 4096 = 0xBB8, read as -1096.
- Overrun: vel_ready=0 and a second tick arrives mid-scan -> overrun=1 and stays 1; only 4 records are produced; the next tick after busy=0 starts a normal scan.
- Reset mid-scan: assert reset_n=0 during PRESENT -> vel_valid=0 and busy=0 immediately; the next tick yields vel_data=0 for all channels.
